mem_lsu: RTL
============

Name: mem_lsu

Overview:
- Load/store initiator that drives the data port of the core's byte-addressed, big-endian dual-port RAM.
- Accepts one LB/LBU/LH/LHU/LW/SB/SH/SW request at a time from the MEM stage.
- Issues word-aligned RAM accesses, extracts and sign-extends load data, and does read-modify-write for sub-word stores, because the RAM only writes full words.
- Stalls the pipeline through busy_o until the response pulse.

Parameters:
- RAM_SIZE, 4096, RAM size in bytes; req_addr_i >= RAM_SIZE is an access error.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_i  in  1  request strobe; sampled only in IDLE
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 half, 10 word; 11 is an error
- req_unsigned_i  in  1  zero-extend the load (LBU/LHU)
- req_addr_i  in  `ADDR_WIDTH  byte address
- req_wdata_i  in  `DATA_WIDTH  store data, right-justified
- busy_o  out  1  state != IDLE; pipeline stall
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_rdata_o  out  `DATA_WIDTH  load result; 0 for stores and errors
- rsp_err_o  out  1  misaligned, out-of-range or bad size; valid with rsp_valid_o
- mem_addr_o  out  `ADDR_WIDTH  word-aligned address {addr[31:2],2'b00}
- mem_we_o  out  1  `WRITE_ENABLE for exactly one cycle per store
- mem_data_o  out  `DATA_WIDTH  write word; `ZERO when mem_we_o is inactive
- mem_data_i  in  `DATA_WIDTH  RAM read word, combinational from mem_addr_o

Behaviour:
- Reset (rst_i=1 at posedge): state IDLE; busy_o, rsp_valid_o, rsp_err_o and mem_we_o = 0; rsp_rdata_o, mem_addr_o and mem_data_o = `ZERO.
- Reset mid-operation aborts the request: no write is issued afterwards and no response is produced.
- Byte lanes (big-endian):
  - offset 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - half at offset 0 -> [31:16], half at offset 2 -> [15:0].
- States: IDLE, LOAD, WRITE, RESP.
- IDLE, req_i=1 (acceptance cycle C0): latch all req_* fields. Error conditions are half with addr[0]=1, word with addr[1:0]!=0, size 11, or addr >= RAM_SIZE.
  - error -> RESP with err=1; no RAM access.
  - load -> LOAD.
  - SW -> WRITE.
  - SB/SH -> LOAD.
- LOAD (C1): mem_addr_o holds the aligned address; mem_data_i is captured at the end of the cycle.
  - load -> RESP with the extracted lane, sign-extended unless req_unsigned_i.
  - sub-word store -> WRITE with the merged word: captured word with the target lane replaced by req_wdata_i[7:0] or [15:0].
- WRITE: mem_we_o active for one cycle; mem_addr_o is the aligned address; mem_data_o is req_wdata_i (SW) or the merged word. Next state RESP.
- RESP: rsp_valid_o=1 for one cycle; rsp_rdata_o and rsp_err_o are registered and held until the next RESP. Next state IDLE.
- Latency, with C0 the acceptance cycle:
  - load: rsp at C2.
  - SW: write C1, rsp C2.
  - SB/SH: read C1, write C2, rsp C3.
  - error: rsp C1.
- busy_o = (state != IDLE). req_i is ignored while busy; the requester holds fields only in C0.
- A new request is accepted in the cycle after RESP (IDLE); there is no back-to-back acceptance in RESP.
- mem_addr_o is held stable through LOAD→WRITE of one RMW, so no other access intervenes.

Decomposition:
- Shared defines/package: size encodings (SIZE_B, SIZE_H, SIZE_W), state encoding, reuse of `ADDR_WIDTH/`DATA_WIDTH/`WRITE_ENABLE/`ZERO.
- Sub-module lsu_lane_align (combinational): inputs word, offset[1:0], size, unsigned, wdata; outputs extracted load value and merged store word. Unit-testable on its own.

Test Plan (RAM word at 0x100 preloaded 0x8899AABB):
1. LW 0x100 -> busy_o C1–C2, rsp_valid_o at C2, rdata 0x8899AABB, err 0, mem_we_o never active.
2. LB 0x101 -> 0xFFFFFF99; LBU 0x103 -> 0x000000BB; LH 0x102 -> 0xFFFFAABB; LHU 0x100 -> 0x00008899.
3. SB 0x102 wdata 0x12345677 -> mem_we_o only in C2 with mem_data_o 0x889977BB, rsp at C3; then LW 0x100 -> 0x889977BB. SH 0x102 wdata 0xCAFE -> word 0x8899CAFE.
4. SW 0x101, LH 0x103, size 11, and LW 0x1000 (RAM_SIZE 4096) -> rsp at C1, err 1, rdata 0, mem_we_o never active, RAM unchanged.
5. req_i held high with new fields during C1–C3 of an SB -> ignored; exactly one write and one rsp pulse; next request is accepted in the cycle after RESP.
6. Reset asserted in the LOAD cycle of SB 0x100 -> no mem_we_o, no rsp_valid_o, busy_o=0 next cycle, word still 0x8899AABB; next LW works normally.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared widths, encodings and request-check helper for the mem_lsu load/store initiator.
package mem_lsu_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic [DATA_WIDTH-1:0] ZERO = '0;

    typedef enum logic [1:0] {
        SIZE_B   = 2'b00,
        SIZE_H   = 2'b01,
        SIZE_W   = 2'b10,
        SIZE_BAD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_RESP
    } state_e;

    // Size/alignment part of the error check; the range check needs RAM_SIZE and lives in the top.
    function automatic logic size_or_align_err(input size_e size, input logic [1:0] offset);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return offset[0];
            SIZE_W:  return offset != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Request/response and RAM data-port bundle of the load/store unit; names are from the LSU's view.
interface mem_lsu_if;
    import mem_lsu_pkg::*;

    logic                  req_i;
    logic                  req_we_i;
    logic [1:0]            req_size_i;
    logic                  req_unsigned_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic                  busy_o;
    logic                  rsp_valid_o;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_we_o;
    logic [DATA_WIDTH-1:0] mem_data_o;
    logic [DATA_WIDTH-1:0] mem_data_i;

    modport master (
        output req_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, mem_data_i,
        input  busy_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, mem_addr_o, mem_we_o, mem_data_o
    );

    modport slave (
        input  req_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, mem_data_i,
        output busy_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, mem_addr_o, mem_we_o, mem_data_o
    );

endinterface

// File: rtl/mem_lsu_lane_align.sv
// Big-endian lane extraction (with sign/zero extension) and sub-word store merge for one RAM word.
module lsu_lane_align
    import mem_lsu_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic [1:0]            i_offset,
    input  size_e                 i_size,
    input  logic                  i_unsigned,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_load,
    output logic [DATA_WIDTH-1:0] o_merged
);

    logic [4:0]            w_byte_sh;
    logic [4:0]            w_half_sh;
    logic [DATA_WIDTH-1:0] w_byte_word;
    logic [DATA_WIDTH-1:0] w_half_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;

    // Offset 0 is the most significant lane, so the lane sits (3 - offset) bytes above bit 0.
    assign w_byte_sh   = {~i_offset, 3'b000};
    assign w_half_sh   = {~i_offset[1], 4'b0000};
    assign w_byte_word = i_word >> w_byte_sh;
    assign w_half_word = i_word >> w_half_sh;
    assign w_byte      = w_byte_word[7:0];
    assign w_half      = w_half_word[15:0];

    // NOTE: both outputs get a default first so no path leaves them unassigned and no latch is inferred.
    always_comb begin
        o_load   = i_word;
        o_merged = i_wdata;
        case (i_size)
            SIZE_B: begin
                o_load   = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
                o_merged = (i_word & ~(32'h0000_00FF << w_byte_sh))
                         | ({24'h0, i_wdata[7:0]} << w_byte_sh);
            end
            SIZE_H: begin
                o_load   = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
                o_merged = (i_word & ~(32'h0000_FFFF << w_half_sh))
                         | ({16'h0, i_wdata[15:0]} << w_half_sh);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator: one request at a time, word-aligned RAM accesses, read-modify-write for SB/SH.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int RAM_SIZE = 4096
) (
    input logic      clk_i,
    input logic      rst_i,
    mem_lsu_if.slave bus
);

    state_e                r_state;
    state_e                w_next;
    logic                  r_we;
    logic                  r_unsigned;
    size_e                 r_size;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_word;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic                  w_req_err;
    logic [DATA_WIDTH-1:0] w_load;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_req_err = size_or_align_err(size_e'(bus.req_size_i), bus.req_addr_i[1:0])
                    || (bus.req_addr_i >= ADDR_WIDTH'(RAM_SIZE));

    lsu_lane_align u_lane_align (
        .i_word     (bus.mem_data_i),
        .i_offset   (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_merged   (w_merged)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_i) begin
                    if (w_req_err)
                        w_next = ST_RESP;
                    else if (bus.req_we_i && size_e'(bus.req_size_i) == SIZE_W)
                        w_next = ST_WRITE;
                    else
                        w_next = ST_LOAD;
                end
            end
            ST_LOAD:  w_next = r_we ? ST_WRITE : ST_RESP;
            ST_WRITE: w_next = ST_RESP;
            default:  w_next = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples the values from before the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= SIZE_B;
            r_addr     <= '0;
            r_wdata    <= ZERO;
            r_word     <= ZERO;
            r_rdata    <= ZERO;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_i) begin
                        r_we       <= bus.req_we_i;
                        r_size     <= size_e'(bus.req_size_i);
                        r_unsigned <= bus.req_unsigned_i;
                        r_addr     <= bus.req_addr_i;
                        r_wdata    <= bus.req_wdata_i;
                        r_word     <= bus.req_wdata_i;
                        if (w_req_err) begin
                            r_rdata <= ZERO;
                            r_err   <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (r_we) begin
                        r_word <= w_merged;
                    end else begin
                        r_rdata <= w_load;
                        r_err   <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    r_rdata <= ZERO;
                    r_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // The latched address drives the RAM through LOAD and WRITE, keeping an RMW pair atomic.
    assign bus.mem_addr_o  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign bus.mem_we_o    = (r_state == ST_WRITE) ? WRITE_ENABLE : ~WRITE_ENABLE;
    assign bus.mem_data_o  = (r_state == ST_WRITE) ? r_word : ZERO;
    assign bus.busy_o      = (r_state != ST_IDLE);
    assign bus.rsp_valid_o = (r_state == ST_RESP);
    assign bus.rsp_rdata_o = r_rdata;
    assign bus.rsp_err_o   = r_err;

endmodule
